// File: rtl/cam_match_resolver_pkg.sv
// ---------------------------------------------------------------------------
// cam_match_resolver_pkg
//   Shared types and helpers for the CAM search front-end.
//   - state_t   : resolver FSM states (IDLE / LOOKUP / EMIT)
//   - idx_width : index width derived from the CAM depth
//   - popcount  : number of set bits in a match vector (zero-extended to
//                 MAX_DEPTH bits by the caller)
// ---------------------------------------------------------------------------
package cam_match_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    // Upper bound on CAM depth that the popcount helper handles.
    localparam int MAX_DEPTH = 1024;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_match_resolver_prio_enc.sv
// ---------------------------------------------------------------------------
// cam_match_resolver_prio_enc
//   Purely combinational lowest-index priority encoder for a CAM match vector.
//   Ports:
//     vec     in   DEPTH   match vector
//     idx     out  IDX_W   index of the lowest set bit (0 when vec == 0)
//     any     out  1       at least one bit of vec is set
//     lowest  out  DEPTH   one-hot of the lowest set bit (all zero when
//                          vec == 0); vec & ~lowest clears that bit
// ---------------------------------------------------------------------------
module cam_match_resolver_prio_enc #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [DEPTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [DEPTH-1:0] lowest
);

    // Scan from the top down so the last (lowest) set bit wins.
    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any    = |vec;
    // Two's-complement trick isolates the lowest set bit.
    assign lowest = vec & (~vec + DEPTH'(1));

endmodule

// File: rtl/cam_match_resolver.sv
// ---------------------------------------------------------------------------
// cam_match_resolver
//   Search front-end for the CAM. Accepts a key on the request port, drives it
//   to the CAM, captures the match vector one cycle later and returns the
//   matching indices (lowest only, or all in ascending order) on the
//   response port.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both 1. Once rsp_valid rises it stays high, with every rsp_* field
//   stable, until the consumer takes it; req_ready is 1 only in IDLE.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid/req_ready/req_key/req_all   search request
//     cam_key      key to CAM data_in (registered, held for the search)
//     cam_match    CAM match vector (combinational from cam_key)
//     rsp_valid/rsp_ready/rsp_hit/rsp_index/rsp_count/rsp_last   responses
//     dbg_state    current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module cam_match_resolver
    import cam_match_resolver_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_key,
    input  logic             req_all,
    output logic [WIDTH-1:0] cam_key,
    input  logic [DEPTH-1:0] cam_match,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_index,
    output logic [IDX_W:0]   rsp_count,
    output logic             rsp_last,
    output logic [1:0]       dbg_state
);

    state_t               state;
    logic                 all_q;
    logic [DEPTH-1:0]     match_q;

    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_any;
    logic [DEPTH-1:0]     enc_lowest;
    logic                 one_left;
    logic                 last_c;
    logic [MAX_DEPTH-1:0] pc_in;
    logic [IDX_W:0]       count_next;

    cam_match_resolver_prio_enc #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec    (match_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .lowest (enc_lowest)
    );

    assign pc_in      = MAX_DEPTH'(cam_match);
    assign count_next = (IDX_W + 1)'(popcount(pc_in));

    // Exactly one bit set: removing the lowest one leaves nothing.
    assign one_left = enc_any && ((match_q & ~enc_lowest) == '0);
    assign last_c   = !enc_any || !all_q || one_left;

    // Outputs are decodes of registered state only.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_EMIT);
    assign rsp_hit   = rsp_valid && enc_any;
    assign rsp_index = rsp_valid ? enc_idx : '0;
    assign rsp_last  = rsp_valid && last_c;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cam_key   <= '0;
            all_q     <= 1'b0;
            match_q   <= '0;
            rsp_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cam_key <= req_key;
                        all_q   <= req_all;
                        state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Snapshot the match vector; later CAM writes cannot
                    // disturb this search.
                    match_q   <= cam_match;
                    rsp_count <= count_next;
                    state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (rsp_ready) begin
                        if (last_c) begin
                            // Lowest-only mode may leave other hits behind;
                            // drop them with the search.
                            match_q   <= '0;
                            rsp_count <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            match_q <= match_q & ~enc_lowest;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_match_resolver.sv
// ---------------------------------------------------------------------------
// tb_cam_match_resolver
//   Directed bench for cam_match_resolver (WIDTH=8, DEPTH=16). A small CAM
//   model returns cam_pattern when cam_key equals the key of the current
//   search, zero otherwise.
// ---------------------------------------------------------------------------
module tb_cam_match_resolver;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_key;
    logic             req_all;
    logic [WIDTH-1:0] cam_key;
    logic [DEPTH-1:0] cam_match;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_index;
    logic [IDX_W:0]   rsp_count;
    logic             rsp_last;
    logic [1:0]       dbg_state;

    logic [WIDTH-1:0] cur_key;
    logic [DEPTH-1:0] cam_pattern;

    int total;
    int bad;

    cam_match_resolver #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_all   (req_all),
        .cam_key   (cam_key),
        .cam_match (cam_match),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .rsp_count (rsp_count),
        .rsp_last  (rsp_last),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CAM model
    always_comb begin
        cam_match = '0;
        if (cam_key == cur_key) begin
            cam_match = cam_pattern;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one search; returns at the first EMIT cycle (cycle 2).
    task automatic do_req(input string tag, input logic [WIDTH-1:0] k,
                          input logic a, input logic [DEPTH-1:0] pat);
        cur_key     = k;
        cam_pattern = pat;
        req_valid   = 1'b1;
        req_key     = k;
        req_all     = a;
        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        // Post-accept changes must be ignored.
        req_key   = ~k;
        req_all   = ~a;
        chk({tag, "_lookup_cam_key"}, 32'(cam_key), 32'(k));
        chk({tag, "_lookup_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_lookup_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_lookup_state"}, 32'(dbg_state), 32'd1);
        step();
    endtask

    task automatic exp_rsp(input string tag, input logic hit, input logic [IDX_W-1:0] idx,
                           input logic [IDX_W:0] cnt, input logic last);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_hit"}, 32'(rsp_hit), 32'(hit));
        chk({tag, "_index"}, 32'(rsp_index), 32'(idx));
        chk({tag, "_count"}, 32'(rsp_count), 32'(cnt));
        chk({tag, "_last"}, 32'(rsp_last), 32'(last));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_key     = '0;
        req_all     = 1'b0;
        rsp_ready   = 1'b0;
        cur_key     = 8'hFF;
        cam_pattern = '0;

        // Reset values
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_hit", 32'(rsp_hit), 32'd0);
        chk("rst_index", 32'(rsp_index), 32'd0);
        chk("rst_count", 32'(rsp_count), 32'd0);
        chk("rst_last", 32'(rsp_last), 32'd0);
        chk("rst_cam_key", 32'(cam_key), 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        exp_idle("post_rst");

        // Single hit, lowest-only
        do_req("single", 8'h3C, 1'b0, 16'h0020);
        exp_rsp("single_r0", 1'b1, 4'd5, 5'd1, 1'b1);
        chk("single_cam_key_hold", 32'(cam_key), 32'h3C);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_idle("single");

        // Multi hit, all mode; CAM contents change mid-search
        do_req("multi", 8'h11, 1'b1, 16'h8421);
        rsp_ready = 1'b1;
        exp_rsp("multi_r0", 1'b1, 4'd0, 5'd4, 1'b0);
        cam_pattern = 16'h0000;
        step();
        exp_rsp("multi_r1", 1'b1, 4'd5, 5'd4, 1'b0);
        step();
        exp_rsp("multi_r2", 1'b1, 4'd10, 5'd4, 1'b0);
        step();
        exp_rsp("multi_r3", 1'b1, 4'd15, 5'd4, 1'b1);
        step();
        rsp_ready = 1'b0;
        exp_idle("multi");

        // Miss
        do_req("miss", 8'h22, 1'b1, 16'h0000);
        exp_rsp("miss_r0", 1'b0, 4'd0, 5'd0, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_idle("miss");

        // Backpressure
        do_req("bp", 8'h33, 1'b1, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            exp_rsp("bp_hold", 1'b1, 4'd8, 5'd2, 1'b0);
            chk("bp_cam_key", 32'(cam_key), 32'h33);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        exp_rsp("bp_r0", 1'b1, 4'd8, 5'd2, 1'b0);
        rsp_ready = 1'b1;
        step();
        exp_rsp("bp_r1", 1'b1, 4'd9, 5'd2, 1'b1);
        chk("bp_cam_key_r1", 32'(cam_key), 32'h33);
        chk("bp_req_ready_r1", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b0;
        exp_idle("bp");

        // Reset in the middle of EMIT
        do_req("mrst", 8'h44, 1'b1, 16'h8421);
        rsp_ready = 1'b1;
        step();
        step();
        exp_rsp("mrst_pre", 1'b1, 4'd10, 5'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_hit", 32'(rsp_hit), 32'd0);
        chk("mrst_index", 32'(rsp_index), 32'd0);
        chk("mrst_count", 32'(rsp_count), 32'd0);
        chk("mrst_last", 32'(rsp_last), 32'd0);
        chk("mrst_cam_key", 32'(cam_key), 32'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mrst_no_stale", 32'(rsp_valid), 32'd0);
            step();
        end
        exp_idle("mrst");
        do_req("mrst_new", 8'h55, 1'b1, 16'h0002);
        exp_rsp("mrst_new_r0", 1'b1, 4'd1, 5'd1, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_idle("mrst_new");

        // All hit, all mode
        do_req("allhit", 8'h66, 1'b1, 16'hFFFF);
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_rsp("allhit_r", 1'b1, 4'(i), 5'd16, (i == DEPTH - 1));
            step();
        end
        rsp_ready = 1'b0;
        exp_idle("allhit");

        // All hit, lowest-only
        do_req("allone", 8'h77, 1'b0, 16'hFFFF);
        exp_rsp("allone_r0", 1'b1, 4'd0, 5'd16, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_idle("allone");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
